// File: rtl/imem_loader.sv
// Instruction memory loader: parses host byte packets (sync, address, length,
// data, checksum) into a local byte memory and exposes a 10-byte combinational
// fetch port. The pipeline is held while a packet is being loaded.
module imem_loader #(
  parameter int          MEM_BYTES = 1024,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        s_valid_i,
  input  logic [7:0]  s_data_i,
  output logic        s_ready_o,
  input  logic [63:0] rd_addr_i,
  output logic [79:0] rd_data_o,
  output logic        rd_err_o,
  output logic        load_busy_o,
  output logic        cpu_hold_o,
  output logic        load_done_o,
  output logic        load_err_o
);

  localparam int          AW        = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [16:0] MEM_LIM17 = 17'(MEM_BYTES);
  localparam logic [64:0] MEM_LIM65 = 65'(MEM_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR_H = 3'd1,
    ST_ADDR_L = 3'd2,
    ST_LEN_H  = 3'd3,
    ST_LEN_L  = 3'd4,
    ST_DATA   = 3'd5,
    ST_CSUM   = 3'd6,
    ST_DONE   = 3'd7
  } state_e;

  state_e      state_q, state_d;
  logic [16:0] ptr_q, ptr_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  hi_q, hi_d;      // holds ADDR_H / LEN_H until the low byte arrives
  logic        ovf_q, ovf_d;
  logic        err_q, err_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        hold_q, hold_d;

  logic        accept_s;
  logic        wr_en_s;
  logic [7:0]  mem [MEM_BYTES];
  logic [79:0] rd_data_s;

  assign accept_s    = s_valid_i & ready_q;
  assign s_ready_o   = ready_q;
  assign load_busy_o = busy_q;
  assign cpu_hold_o  = hold_q;
  assign load_done_o = done_q;
  assign load_err_o  = err_q;

  // Packet parser next-state, datapath and registered-output computation
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    csum_d  = csum_q;
    hi_d    = hi_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    wr_en_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && (s_data_i == SYNC_BYTE)) begin
          state_d = ST_ADDR_H;
          err_d   = 1'b0;
          csum_d  = 8'h00;
          ovf_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR_H: begin
        if (accept_s) begin
          hi_d    = s_data_i;
          csum_d  = csum_q ^ s_data_i;
          state_d = ST_ADDR_L;
        end else begin
          state_d = ST_ADDR_H;
        end
      end
      ST_ADDR_L: begin
        if (accept_s) begin
          ptr_d   = {1'b0, hi_q, s_data_i};
          csum_d  = csum_q ^ s_data_i;
          state_d = ST_LEN_H;
        end else begin
          state_d = ST_ADDR_L;
        end
      end
      ST_LEN_H: begin
        if (accept_s) begin
          hi_d    = s_data_i;
          csum_d  = csum_q ^ s_data_i;
          state_d = ST_LEN_L;
        end else begin
          state_d = ST_LEN_H;
        end
      end
      ST_LEN_L: begin
        if (accept_s) begin
          len_d   = {hi_q, s_data_i};
          csum_d  = csum_q ^ s_data_i;
          state_d = ({hi_q, s_data_i} != 16'h0000) ? ST_DATA : ST_CSUM;
        end else begin
          state_d = ST_LEN_L;
        end
      end
      ST_DATA: begin
        if (accept_s) begin
          csum_d = csum_q ^ s_data_i;
          if (ptr_q < MEM_LIM17) begin
            wr_en_s = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
          // 17-bit pointer cannot wrap: max start 0xFFFF plus max length 0xFFFF
          ptr_d = ptr_q + 17'd1;
          len_d = len_q - 16'd1;
          state_d = (len_q == 16'd1) ? ST_CSUM : ST_DATA;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (accept_s) begin
          state_d = ST_DONE;
          err_d   = (s_data_i != csum_q) | ovf_q;
        end else begin
          state_d = ST_CSUM;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered, so derive them from the next state
    ready_d = (state_d != ST_DONE);
    busy_d  = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d  = (state_d == ST_DONE);
    hold_d  = busy_d | done_d;
  end

  // Parser state, counters, checksum and status flops
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= 17'd0;
      len_q   <= 16'd0;
      csum_q  <= 8'h00;
      hi_q    <= 8'h00;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      csum_q  <= csum_d;
      hi_q    <= hi_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hold_q  <= hold_d;
    end
  end

  // Byte memory write port; contents deliberately survive reset
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem[ptr_q[AW-1:0]] <= s_data_i;
    end
  end

  // Combinational 10-byte fetch; out-of-range bytes read as zero
  always_comb begin
    logic [64:0] a;
    rd_data_s = 80'd0;
    a         = 65'd0;
    for (int k = 0; k < 10; k++) begin
      a = {1'b0, rd_addr_i} + 65'(k);
      if (a < MEM_LIM65) begin
        rd_data_s[79-8*k -: 8] = mem[a[AW-1:0]];
      end else begin
        rd_data_s[79-8*k -: 8] = 8'h00;
      end
    end
  end

  assign rd_data_o = rd_data_s;
  assign rd_err_o  = ({1'b0, rd_addr_i} >= MEM_LIM65);

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

  logic        clk_i;
  logic        rst_n_i;
  logic        s_valid_i;
  logic [7:0]  s_data_i;
  logic        s_ready_o;
  logic [63:0] rd_addr_i;
  logic [79:0] rd_data_o;
  logic        rd_err_o;
  logic        load_busy_o;
  logic        cpu_hold_o;
  logic        load_done_o;
  logic        load_err_o;

  int passed = 0;
  int total  = 0;

  imem_loader dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .s_valid_i   (s_valid_i),
    .s_data_i    (s_data_i),
    .s_ready_o   (s_ready_o),
    .rd_addr_i   (rd_addr_i),
    .rd_data_o   (rd_data_o),
    .rd_err_o    (rd_err_o),
    .load_busy_o (load_busy_o),
    .cpu_hold_o  (cpu_hold_o),
    .load_done_o (load_done_o),
    .load_err_o  (load_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present one byte (after 'gap' idle cycles), wait for acceptance, return at posedge+1
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk_i);
      s_valid_i = 1'b0;
    end
    @(negedge clk_i);
    s_valid_i = 1'b1;
    s_data_i  = b;
    n = 0;
    while (!s_ready_o && n < 16) begin
      @(negedge clk_i);
      n++;
    end
    if (!s_ready_o) chk("ready_timeout", {79'd0, s_ready_o}, 80'd1);
    @(posedge clk_i);
    #1;
    s_valid_i = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] q[$], input int gap);
    foreach (q[i]) send(q[i], gap);
  endtask

  initial begin
    logic [7:0] pkt[$];
    rst_n_i   = 1'b0;
    s_valid_i = 1'b0;
    s_data_i  = 8'h00;
    rd_addr_i = 64'd0;

    // Reset state
    #1;
    chk("rst_ready", {79'd0, s_ready_o},   80'd0);
    chk("rst_busy",  {79'd0, load_busy_o}, 80'd0);
    chk("rst_hold",  {79'd0, cpu_hold_o},  80'd0);
    chk("rst_done",  {79'd0, load_done_o}, 80'd0);
    chk("rst_err",   {79'd0, load_err_o},  80'd0);
    @(negedge clk_i);
    #2 rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("ready_after_release", {79'd0, s_ready_o}, 80'd1);

    // Good packet: XOR of 00 10 00 03 30 F2 0A is DB
    send(8'hA5, 0);
    chk("busy_after_sync", {79'd0, load_busy_o}, 80'd1);
    chk("hold_after_sync", {79'd0, cpu_hold_o},  80'd1);
    pkt = '{8'h00, 8'h10, 8'h00, 8'h03, 8'h30, 8'hF2, 8'h0A, 8'hDB};
    send_pkt(pkt, 0);
    chk("good_done",     {79'd0, load_done_o}, 80'd1);
    chk("good_ready_lo", {79'd0, s_ready_o},   80'd0);
    chk("good_hold",     {79'd0, cpu_hold_o},  80'd1);
    chk("good_busy_lo",  {79'd0, load_busy_o}, 80'd0);
    chk("good_err",      {79'd0, load_err_o},  80'd0);
    @(posedge clk_i);
    #1;
    chk("good_done_1cyc", {79'd0, load_done_o}, 80'd0);
    chk("good_ready_hi",  {79'd0, s_ready_o},   80'd1);
    chk("good_hold_lo",   {79'd0, cpu_hold_o},  80'd0);
    rd_addr_i = 64'h10;
    #1;
    chk("good_rd", {56'd0, rd_data_o[79:56]}, {56'd0, 24'h30F20A});

    // Same packet with bad checksum: bytes written, sticky error
    pkt = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h03, 8'h31, 8'hF3, 8'h0B, 8'h00};
    send_pkt(pkt, 0);
    chk("bad_done", {79'd0, load_done_o}, 80'd1);
    chk("bad_err",  {79'd0, load_err_o},  80'd1);
    #1;
    chk("bad_rd_written", {56'd0, rd_data_o[79:56]}, {56'd0, 24'h31F30B});
    @(posedge clk_i);
    #1;
    chk("bad_err_sticky", {79'd0, load_err_o}, 80'd1);

    // Junk before sync is ignored; sync clears error; LEN=0 writes nothing
    send(8'h00, 0);
    send(8'hFF, 0);
    chk("junk_busy", {79'd0, load_busy_o}, 80'd0);
    chk("junk_err",  {79'd0, load_err_o},  80'd1);
    send(8'hA5, 0);
    chk("sync_clears_err", {79'd0, load_err_o}, 80'd0);
    pkt = '{8'h00, 8'h10, 8'h00, 8'h00, 8'h10};
    send_pkt(pkt, 0);
    chk("len0_done", {79'd0, load_done_o}, 80'd1);
    chk("len0_err",  {79'd0, load_err_o},  80'd0);
    #1;
    chk("len0_nowrite", {56'd0, rd_data_o[79:56]}, {56'd0, 24'h31F30B});
    @(posedge clk_i);

    // Overflow at top of memory: XOR of 03 FE 00 04 11 22 33 44 is BD
    pkt = '{8'hA5, 8'h03, 8'hFE, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'hBD};
    send_pkt(pkt, 0);
    chk("ovf_done", {79'd0, load_done_o}, 80'd1);
    chk("ovf_err",  {79'd0, load_err_o},  80'd1);
    rd_addr_i = 64'h3FE;
    #1;
    chk("ovf_rd",     rd_data_o, 80'h1122_0000_0000_0000_0000);
    chk("ovf_rd_err", {79'd0, rd_err_o}, 80'd0);
    rd_addr_i = 64'd1023;
    #1;
    chk("rd_last",     rd_data_o, 80'h2200_0000_0000_0000_0000);
    chk("rd_last_err", {79'd0, rd_err_o}, 80'd0);
    rd_addr_i = 64'd1024;
    #1;
    chk("rd_oob_data", rd_data_o, 80'd0);
    chk("rd_oob_err",  {79'd0, rd_err_o}, 80'd1);
    @(posedge clk_i);

    // Reset after two data bytes of a LEN=5 packet
    pkt = '{8'hA5, 8'h00, 8'h40, 8'h00, 8'h05, 8'h01, 8'h02};
    send_pkt(pkt, 0);
    chk("mid_busy", {79'd0, load_busy_o}, 80'd1);
    #2 rst_n_i = 1'b0;
    #1;
    chk("mid_rst_busy",  {79'd0, load_busy_o}, 80'd0);
    chk("mid_rst_hold",  {79'd0, cpu_hold_o},  80'd0);
    chk("mid_rst_ready", {79'd0, s_ready_o},   80'd0);
    chk("mid_rst_done",  {79'd0, load_done_o}, 80'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    chk("mid_ready_before_edge", {79'd0, s_ready_o}, 80'd0);
    @(posedge clk_i);
    #1;
    chk("mid_ready_after_edge", {79'd0, s_ready_o}, 80'd1);
    send(8'h03, 0);
    chk("post_rst_idle", {79'd0, load_busy_o}, 80'd0);
    rd_addr_i = 64'h40;
    #1;
    chk("mid_bytes_kept", {64'd0, rd_data_o[79:64]}, {64'd0, 16'h0102});
    // XOR of 00 50 00 01 77 is 26
    pkt = '{8'hA5, 8'h00, 8'h50, 8'h00, 8'h01, 8'h77, 8'h26};
    send_pkt(pkt, 0);
    chk("post_rst_done", {79'd0, load_done_o}, 80'd1);
    chk("post_rst_err",  {79'd0, load_err_o},  80'd0);
    rd_addr_i = 64'h50;
    #1;
    chk("post_rst_rd", {72'd0, rd_data_o[79:72]}, {72'd0, 8'h77});
    @(posedge clk_i);

    // Same kind of packet with idle gaps between bytes: XOR of 00 60 00 02 AB CD is 04
    pkt = '{8'hA5, 8'h00, 8'h60, 8'h00, 8'h02, 8'hAB, 8'hCD, 8'h04};
    send_pkt(pkt, 2);
    chk("gap_done", {79'd0, load_done_o}, 80'd1);
    chk("gap_err",  {79'd0, load_err_o},  80'd0);
    rd_addr_i = 64'h60;
    #1;
    chk("gap_rd", {64'd0, rd_data_o[79:64]}, {64'd0, 16'hABCD});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
